// File: rtl/booth_mac_pkg.sv
// Shared types and helpers for the Booth multiplier MAC accumulator stage.
package booth_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int unsigned PROD_W = 64;
    localparam int unsigned EXT_W  = 128;

    // Widest sign extension of a product; callers truncate to their ACC_W (ACC_W <= EXT_W).
    function automatic logic signed [EXT_W-1:0] ext_prod(input logic signed [PROD_W-1:0] p);
        return {{(EXT_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Product-in / frame-result-out handshake bundle of the MAC accumulator stage.
interface booth_mac_accumulator_if #(
    parameter int unsigned ACC_W     = 72,
    parameter int unsigned MAX_BEATS = 16
);
    import booth_mac_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    logic signed [PROD_W-1:0] in_product;
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic                     in_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]         out_count;
    logic                     out_ovf;
    logic                     out_err;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_product, in_valid, in_first, in_last, out_ready,
        input  in_ready, out_acc, out_count, out_ovf, out_err, out_valid
    );

    modport slave (
        input  in_product, in_valid, in_first, in_last, out_ready,
        output in_ready, out_acc, out_count, out_ovf, out_err, out_valid
    );

endinterface

// File: rtl/booth_mac_addsat.sv
// Combinational ACC_W signed adder with overflow flag.
// Build option BOOTH_MAC_SAT_EN clamps the sum on overflow instead of wrapping.
module booth_mac_addsat #(
    parameter int unsigned ACC_W = 72
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum_c,
    output logic                    o_ovf_c
);

    logic signed [ACC_W-1:0] w_raw;

    assign w_raw   = i_a + i_b;
    // Overflow only when both operands share a sign and the result flips it.
    assign o_ovf_c = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

`ifdef BOOTH_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        o_sum_c = w_raw;
        if (o_ovf_c) begin
            o_sum_c = i_a[ACC_W-1] ? MAX_NEG : MAX_POS;
        end
    end
`else
    assign o_sum_c = w_raw;
`endif

endmodule

// File: rtl/booth_mac_accumulator.sv
// Frames the Booth multiplier product stream and emits per-frame sums over valid/ready.
// Build option BOOTH_MAC_SAT_EN selects saturating accumulation (see booth_mac_addsat).
module booth_mac_accumulator
    import booth_mac_pkg::*;
#(
    parameter int unsigned ACC_W     = 72,
    parameter int unsigned MAX_BEATS = 16
) (
    input logic                     clk,
    input logic                     rst,
    booth_mac_accumulator_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    state_e                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;
    logic signed [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0]        r_out_count;
    logic                    r_out_ovf;
    logic                    r_out_err;
    logic                    r_out_valid;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_drain;
    logic                    w_start;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_add_ovf;
    logic signed [ACC_W-1:0] w_new_acc;
    logic [CNT_W-1:0]        w_new_cnt;
    logic                    w_new_ovf;
    logic                    w_hit_max;
    logic                    w_close;
    logic                    w_err;

    // A held result only blocks input when the consumer is not taking it this cycle.
    assign w_in_ready = (r_state != HOLD) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_drain    = r_out_valid && bus.out_ready;

    assign w_ext = ACC_W'(ext_prod(bus.in_product));

    booth_mac_addsat #(.ACC_W(ACC_W)) u_addsat (
        .i_a     (r_acc),
        .i_b     (w_ext),
        .o_sum_c (w_sum),
        .o_ovf_c (w_add_ovf)
    );

    // Outside ACCUM every accepted beat opens a fresh frame, as does in_first inside it.
    assign w_start   = (r_state != ACCUM) || bus.in_first;
    assign w_new_acc = w_start ? w_ext : w_sum;
    assign w_new_cnt = w_start ? CNT_W'(1) : r_count + CNT_W'(1);
    assign w_new_ovf = w_start ? 1'b0 : (r_ovf || w_add_ovf);
    assign w_hit_max = (w_new_cnt == CNT_W'(MAX_BEATS));
    assign w_close   = bus.in_last || w_hit_max;
    assign w_err     = w_hit_max && !bus.in_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_drain) begin
                r_out_valid <= 1'b0;
                r_state     <= IDLE;
            end
            // A same-cycle accept overrides the drain's return to IDLE.
            if (w_accept) begin
                r_acc   <= w_new_acc;
                r_count <= w_new_cnt;
                r_ovf   <= w_new_ovf;
                if (w_close) begin
                    r_out_acc   <= w_new_acc;
                    r_out_count <= w_new_cnt;
                    r_out_ovf   <= w_new_ovf;
                    r_out_err   <= w_err;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end else begin
                    r_state     <= ACCUM;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_err   = r_out_err;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Scoreboard bench: ACC_W=72 and ACC_W=64 instances share one stimulus stream.
module tb_booth_mac_accumulator;

    localparam int unsigned MAXB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [63:0] d_prod = '0;
    logic d_valid = 1'b0, d_first = 1'b0, d_last = 1'b0, d_rdy = 1'b1;
    bit   rand_rdy = 1'b0;

    booth_mac_accumulator_if #(.ACC_W(72), .MAX_BEATS(MAXB)) bus72 ();
    booth_mac_accumulator_if #(.ACC_W(64), .MAX_BEATS(MAXB)) bus64 ();

    assign bus72.in_product = d_prod;
    assign bus72.in_valid   = d_valid;
    assign bus72.in_first   = d_first;
    assign bus72.in_last    = d_last;
    assign bus72.out_ready  = d_rdy;
    assign bus64.in_product = d_prod;
    assign bus64.in_valid   = d_valid;
    assign bus64.in_first   = d_first;
    assign bus64.in_last    = d_last;
    assign bus64.out_ready  = d_rdy;

    booth_mac_accumulator #(.ACC_W(72), .MAX_BEATS(MAXB)) dut72 (.clk(clk), .rst(rst), .bus(bus72));
    booth_mac_accumulator #(.ACC_W(64), .MAX_BEATS(MAXB)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    typedef struct {
        logic signed [127:0] acc72;
        bit                  ovf72;
        logic signed [127:0] acc64;
        bit                  ovf64;
        int                  cnt;
        bit                  err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference frame state: exact integers, clamped or wrapped to each width.
    bit                  m_in_frame = 1'b0;
    logic signed [127:0] m_acc72, m_acc64;
    bit                  m_ovf72, m_ovf64;
    int                  m_cnt = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_add(input logic signed [127:0] a, input logic signed [127:0] p,
                                      input int w, output logic signed [127:0] r, output bit ovf);
        logic signed [127:0] exact, maxv, minv;
        exact = a + p;
        maxv  = (128'sd1 <<< (w - 1)) - 128'sd1;
        minv  = -maxv - 128'sd1;
        ovf   = (exact > maxv) || (exact < minv);
`ifdef BOOTH_MAC_SAT_EN
        r = (exact > maxv) ? maxv : ((exact < minv) ? minv : exact);
`else
        r = (exact <<< (128 - w)) >>> (128 - w);
`endif
    endfunction

    function automatic void model_accept(input logic signed [63:0] p, input bit first, input bit last);
        logic signed [127:0] pe;
        bit o;
        exp_t e;
        pe = p;
        if (!m_in_frame || first) begin
            m_acc72 = pe; m_acc64 = pe;
            m_ovf72 = 1'b0; m_ovf64 = 1'b0;
            m_cnt   = 1;
        end else begin
            model_add(m_acc72, pe, 72, m_acc72, o); m_ovf72 |= o;
            model_add(m_acc64, pe, 64, m_acc64, o); m_ovf64 |= o;
            m_cnt++;
        end
        m_in_frame = 1'b1;
        if (last || m_cnt == MAXB) begin
            e.acc72 = m_acc72; e.ovf72 = m_ovf72;
            e.acc64 = m_acc64; e.ovf64 = m_ovf64;
            e.cnt   = m_cnt;   e.err   = (m_cnt == MAXB) && !last;
            q.push_back(e);
            m_in_frame = 1'b0;
        end
    endfunction

    // Monitor: output presence, in_ready rule, and popped results on each drain.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid72", 128'(bus72.out_valid), 128'(q.size() != 0));
            chk("valid64", 128'(bus64.out_valid), 128'(q.size() != 0));
            chk("in_ready72", 128'(bus72.in_ready), 128'((q.size() == 0) || d_rdy));
            chk("in_ready64", 128'(bus64.in_ready), 128'((q.size() == 0) || d_rdy));
            if (bus72.out_valid && d_rdy && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("acc72",   128'(bus72.out_acc),   e.acc72);
                chk("ovf72",   128'(bus72.out_ovf),   128'(e.ovf72));
                chk("acc64",   128'(bus64.out_acc),   e.acc64);
                chk("ovf64",   128'(bus64.out_ovf),   128'(e.ovf64));
                chk("count72", 128'(bus72.out_count), 128'(e.cnt));
                chk("count64", 128'(bus64.out_count), 128'(e.cnt));
                chk("err72",   128'(bus72.out_err),   128'(e.err));
                chk("err64",   128'(bus64.out_err),   128'(e.err));
            end
        end
    end

    task automatic step_ready();
        if (rand_rdy) d_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic signed [63:0] p, input bit first, input bit last);
        bit accepted = 1'b0;
        d_prod = p; d_first = first; d_last = last; d_valid = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk); #2;
            if (bus72.in_ready) begin
                accepted = 1'b1;
                model_accept(p, first, last);
            end
            @(posedge clk); #1;
            step_ready();
        end
        d_valid = 1'b0; d_first = 1'b0; d_last = 1'b0;
        chk("accept_timeout", 128'(accepted), 128'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            step_ready();
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_acc72",   128'(bus72.out_acc),   128'(0));
        chk("rst_acc64",   128'(bus64.out_acc),   128'(0));
        chk("rst_count",   128'(bus72.out_count), 128'(0));
        chk("rst_ovf",     128'(bus72.out_ovf),   128'(0));
        chk("rst_err",     128'(bus72.out_err),   128'(0));
        chk("rst_valid72", 128'(bus72.out_valid), 128'(0));
        chk("rst_valid64", 128'(bus64.out_valid), 128'(0));
    endtask

    task automatic pulse_reset();
        d_valid = 1'b0; rst = 1'b1;
        m_in_frame = 1'b0;
        q.delete();
        @(posedge clk); #1;
        check_reset_outputs();
        rst = 1'b0;
    endtask

    initial begin
        logic signed [63:0] p;
        int s;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Basic frame: 5 + 7 - 3 = 9
        send_beat(64'sd5, 1, 0);
        send_beat(64'sd7, 0, 0);
        send_beat(-64'sd3, 0, 1);
        idle(3);

        // Backpressure: 200 waits behind a held 100, then drains and accepts together
        d_rdy = 1'b0;
        send_beat(64'sd100, 1, 1);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 d_rdy = 1'b1;
            end
        join_none
        send_beat(64'sd200, 1, 1);
        idle(3);

        // Overflow at the 64-bit width
        send_beat(64'sh7FFF_FFFF_FFFF_FFFF, 1, 0);
        send_beat(64'sd1, 0, 1);
        idle(2);

        // Forced close at MAX_BEATS, then the next beat opens a new frame
        for (int i = 0; i < MAXB; i++) send_beat(64'sd1, i == 0, 0);
        send_beat(64'sd5, 0, 1);
        idle(2);

        // Restart discards the partial frame
        send_beat(64'sd10, 1, 0);
        send_beat(64'sd20, 0, 0);
        send_beat(64'sd30, 1, 0);
        send_beat(64'sd4, 0, 1);
        idle(2);

        // Reset mid-frame
        send_beat(64'sd1, 1, 0);
        send_beat(64'sd2, 0, 0);
        pulse_reset();
        send_beat(64'sd8, 1, 1);
        idle(2);

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: p = {$urandom(), $urandom()};
                1: p = ($urandom_range(0, 1) != 0) ? 64'sh7FFF_FFFF_FFFF_FFF0 : 64'sh8000_0000_0000_0010;
                default: begin
                    s = int'($urandom_range(0, 2000)) - 1000;
                    p = 64'(s);
                end
            endcase
            send_beat(p, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        end

        rand_rdy = 1'b0;
        d_rdy = 1'b1;
        idle(5);
        chk("queue_empty", 128'(q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
